sumador_serial: RTL
===================

# sumador_serial

Bit-serial N-bit adder. It accepts two WIDTH-bit operands and a carry-in on a start pulse and resolves them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It returns the sum and carry-out with a one-cycle done pulse. It is the adder counterpart of the 1-bit subtractor cell: subtraction is done by the caller feeding `~in_b` with `in_ci = 1`. It sits in the arithmetic datapath wherever area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and sum width in bits, minimum 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_start`  input  1  start request, sampled at rising edge.
- `in_a`  input  WIDTH  operand A, captured on accepted start.
- `in_b`  input  WIDTH  operand B, captured on accepted start.
- `in_ci`  input  1  carry-in, captured on accepted start.
- `out_busy`  output  1  high while bits are being processed.
- `out_done`  output  1  one-cycle pulse: result valid.
- `out_s`  output  WIDTH  sum, held until next accepted start.
- `out_co`  output  1  carry-out, held with `out_s`.
- `out_ov`  output  1  signed overflow (only with `SUMADOR_SERIAL_OVF_EN`).

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one cycle, result presented.
- IDLE -> RUN on `in_start = 1`:
  - Load A and B shift registers and the carry flip-flop with `in_ci`.
  - Clear the bit counter.
  - Clear `out_s`, `out_co` and `out_ov`.
- RUN, every edge:
  - The full adder combines `a[0]`, `b[0]` and the carry flip-flop.
  - The sum bit shifts into the MSB of the sum register; the A and B registers shift right.
  - The carry flip-flop takes the cell's carry-out.
  - The counter increments.
- RUN -> DONE on the edge that processes bit WIDTH-1. `out_co` is the final carry flip-flop value.
- DONE -> IDLE unconditionally, or DONE -> RUN if `in_start = 1` (back-to-back operation, no idle cycle).
- `in_start` during RUN is ignored. Operands are not re-sampled.
- `out_s` and `out_co` hold their DONE value through IDLE until the next accepted start.
- The counter is `$clog2(WIDTH)+1` bits wide. For WIDTH = 1, RUN lasts exactly one edge.
- Reset, including mid-RUN:
  - Aborts the operation and forces IDLE.
  - All outputs go to 0: `out_busy`, `out_done`, `out_s`, `out_co`, `out_ov`.
  - No partial result is ever flagged done.

## Timing
- Edge 0 accepts start. `out_busy` = 1 from edge 0 through edge WIDTH.
- Bits are processed on edges 1..WIDTH.
- `out_done` = 1 in the cycle following edge WIDTH, for exactly one cycle; `out_s`/`out_co` are valid in the same cycle.
- Latency from start sample to done: WIDTH+1 edges.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SUMADOR_SERIAL_OVF_EN` defined:
  - `out_ov` port exists.
  - It registers carry-into-MSB XOR carry-out-of-MSB at the last RUN edge.
  - It is valid and held with `out_s`; it is 0 after reset or an accepted start.
- Undefined: `out_ov` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `sumador_pkg` holds:
  - The state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - The default width constant.
- Sub-module `sumador_completo`: combinational 1-bit full adder (b, a, ci -> co, s), built from two `halfadder` instances plus an OR, instantiated once.

## Test plan
- WIDTH = 8, A = 0x3C, B = 0x0F, ci = 0 -> `out_s` = 0x4B, `out_co` = 0, `out_done` exactly 9 edges after the start edge.
- A = 0xFF, B = 0x01, ci = 0 -> `out_s` = 0x00, `out_co` = 1. Then back-to-back start in DONE with A = 0x01, B = 0x01 -> 0x02, `out_co` = 0, no idle cycle.
- Subtraction: A = 0x05, B = ~0x07 = 0xF8, ci = 1 -> `out_s` = 0xFE, `out_co` = 0 (borrow). A = 0x07, B = 0xFA, ci = 1 -> `out_s` = 0x02, `out_co` = 1.
- Start A = 0x10, B = 0x20; pulse start again with A = 0xFF at edge 3 -> ignored, result 0x30, single done pulse.
- Start, then assert `rst_n` = 0 at edge 4 -> all outputs 0 immediately, IDLE after release. No `out_done` until a new start.
- With `SUMADOR_SERIAL_OVF_EN`: 0x7F + 0x01 -> `out_s` = 0x80, `out_ov` = 1, `out_co` = 0. 0xFF + 0x01 -> `out_ov` = 0.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared package for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package sumador_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sumador_state_t;

    localparam int SUMADOR_WIDTH_DEF = 8;

endpackage

// File: rtl/halfadder.sv
// 1-bit half adder.
// Ports:
//   a, b : input bits
//   s    : sum (a ^ b)
//   c    : carry (a & b)
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/sumador_completo.sv
// Combinational 1-bit full adder built from two half adders and an OR.
// Ports:
//   b, a, ci : input bits and carry-in
//   co       : carry-out
//   s        : sum bit
module sumador_completo (
    input  logic b,
    input  logic a,
    input  logic ci,
    output logic co,
    output logic s
);

    logic s1;
    logic c1;
    logic c2;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    halfadder u_ha1 (
        .a (s1),
        .b (ci),
        .s (s),
        .c (c2)
    );

    // The two half-adder carries can never both be 1, so OR is exact.
    assign co = c1 | c2;

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// resolving the operands LSB-first, one bit per clock.
//
// Optional feature: define SUMADOR_SERIAL_OVF_EN to add the out_ov port
// (signed overflow, registered at the last RUN edge).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_start   : start request (accepted in IDLE or DONE, ignored in RUN)
//   in_a, in_b : operands, captured on an accepted start
//   in_ci      : carry-in, captured on an accepted start
//   out_busy   : high while bits are being processed
//   out_done   : one-cycle pulse, result valid
//   out_s      : sum, held until the next accepted start
//   out_co     : carry-out, held with out_s
//   out_ov     : signed overflow (SUMADOR_SERIAL_OVF_EN only)
//   dbg_state  : current FSM state, for observation
//
// Handshake: a start is taken on any rising edge where in_start = 1 and the
// block is in IDLE or DONE. The result is valid exactly in the cycle where
// out_done = 1 and stays on out_s/out_co until the next accepted start.
// There is no back-pressure; a start seen during RUN is dropped.
module sumador_serial
    import sumador_pkg::*;
#(
    parameter int WIDTH = SUMADOR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
`ifdef SUMADOR_SERIAL_OVF_EN
    output logic             out_ov,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sumador_state_t   state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH:0]   s_shift;
    logic             accept;

    sumador_completo u_fa (
        .b  (b_q[0]),
        .a  (a_q[0]),
        .ci (c_q),
        .co (fa_co),
        .s  (fa_s)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
    // Built with a concatenation so WIDTH = 1 needs no special case.
    assign s_shift = {fa_s, out_s};

    assign accept    = in_start && ((state == S_IDLE) || (state == S_DONE));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            cnt      <= '0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_s    <= '0;
            out_co   <= 1'b0;
`ifdef SUMADOR_SERIAL_OVF_EN
            out_ov   <= 1'b0;
`endif
        end else if (accept) begin
            // Same load from IDLE and from DONE, so back-to-back needs no gap.
            state    <= S_RUN;
            a_q      <= in_a;
            b_q      <= in_b;
            c_q      <= in_ci;
            cnt      <= '0;
            out_busy <= 1'b1;
            out_done <= 1'b0;
            out_s    <= '0;
            out_co   <= 1'b0;
`ifdef SUMADOR_SERIAL_OVF_EN
            out_ov   <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    out_s <= s_shift[WIDTH:1];
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state    <= S_DONE;
                        out_busy <= 1'b0;
                        out_done <= 1'b1;
                        out_co   <= fa_co;
`ifdef SUMADOR_SERIAL_OVF_EN
                        // c_q is the carry into the MSB on this edge.
                        out_ov   <= c_q ^ fa_co;
`endif
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    out_done <= 1'b0;
                end
                S_IDLE: begin
                    out_done <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    out_busy <= 1'b0;
                    out_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
